// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, the XZR index
// and the ID/EX payload layout.
package alu_pkg;

  localparam int DATA_W = 64;
  localparam int REG_W  = 5;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  // Index of the hard-wired zero register; never a forwarding source
  localparam logic [REG_W-1:0] XZR = 5'd31;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic              b_imm;
    logic [3:0]        ctl;
    logic [REG_W-1:0]  rd;
    logic              wr;
  } s1_t;

endpackage

// File: rtl/alu.sv
// Combinational 64-bit ALU; zero latency, no handshake.
// Undefined operation codes return all-ones; arithmetic wraps with no carry out.
module alu
  import alu_pkg::*;
#(
  parameter int N = DATA_W
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ctl,
  output logic [N-1:0] y
);

  always_comb begin
    y = '1;
    case (ctl)
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_PASSB: y = b;
      default:   y = '1;
    endcase
  end

endmodule

// File: rtl/alu_pipe_stage.sv
// Elastic ID/EX -> EX/MEM execute stage with EX/MEM-to-operand forwarding; result
// registered one edge after ID/EX capture. Stalls on out_ready=0; flush kills ID/EX.
module alu_pipe_stage
  import alu_pkg::*;
#(
  parameter int N  = DATA_W,
  parameter int RW = REG_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic [RW-1:0] in_rs1,
  input  logic [RW-1:0] in_rs2,
  input  logic          in_b_imm,
  input  logic [3:0]    in_alu_ctl,
  input  logic [RW-1:0] in_rd,
  input  logic          in_wr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_result,
  output logic          out_zero,
  output logic [RW-1:0] out_rd,
  output logic          out_wr
);

  s1_t           s1_q;
  s1_t           s1_d;
  logic          s1_vld;
  logic          s2_vld;
  logic [N-1:0]  s2_result;
  logic          s2_zero;
  logic [RW-1:0] s2_rd;
  logic          s2_wr;

  logic          adv1;
  logic          adv2;
  logic          accept;
  logic          fwd_a;
  logic          fwd_b;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic [N-1:0]  alu_y;

  // A flushed ID/EX entry must not slip into EX/MEM on the same edge.
  assign adv2     = !s2_vld || out_ready;
  assign adv1     = s1_vld && adv2 && !flush;
  assign in_ready = !flush && (!s1_vld || adv2);
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_d       = s1_q;
    s1_d.a     = in_a;
    s1_d.b     = in_b;
    s1_d.rs1   = in_rs1;
    s1_d.rs2   = in_rs2;
    s1_d.b_imm = in_b_imm;
    s1_d.ctl   = in_alu_ctl;
    s1_d.rd    = in_rd;
    s1_d.wr    = in_wr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
    end else if (accept) begin
      s1_vld <= 1'b1;
      s1_q   <= s1_d;
    end else if (adv1 || flush) begin
      s1_vld <= 1'b0;
    end
  end

  // EX/MEM holds the only in-flight older result; older ones are in the register file.
  assign fwd_a = s2_vld && s2_wr && (s2_rd == s1_q.rs1) && (s1_q.rs1 != XZR);
  assign fwd_b = s2_vld && s2_wr && (s2_rd == s1_q.rs2) && (s1_q.rs2 != XZR) && !s1_q.b_imm;
  assign op_a  = fwd_a ? s2_result : s1_q.a;
  assign op_b  = fwd_b ? s2_result : s1_q.b;

  alu #(.N(N)) u_alu (
    .a   (op_a),
    .b   (op_b),
    .ctl (s1_q.ctl),
    .y   (alu_y)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_vld    <= 1'b0;
      s2_result <= '0;
      s2_zero   <= 1'b0;
      s2_rd     <= '0;
      s2_wr     <= 1'b0;
    end else if (adv1) begin
      s2_vld    <= 1'b1;
      s2_result <= alu_y;
      s2_zero   <= (alu_y == '0);
      s2_rd     <= s1_q.rd;
      s2_wr     <= s1_q.wr;
    end else if (adv2) begin
      s2_vld    <= 1'b0;
    end
  end

  assign out_valid  = s2_vld;
  assign out_result = s2_result;
  assign out_zero   = s2_zero;
  assign out_rd     = s2_rd;
  assign out_wr     = s2_wr;

endmodule

// File: tb/tb_alu_pipe_stage.sv
// Scoreboard bench for alu_pipe_stage: expectations are computed from a reference
// ALU plus a one-deep forwarding model when an operation is accepted.
module tb_alu_pipe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic        in_b_imm;
  logic [3:0]  in_alu_ctl;
  logic [4:0]  in_rd;
  logic        in_wr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic        out_wr;

  alu_pipe_stage dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_b_imm   (in_b_imm),
    .in_alu_ctl (in_alu_ctl),
    .in_rd      (in_rd),
    .in_wr      (in_wr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_rd     (out_rd),
    .out_wr     (out_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic        z;
    logic [4:0]  rd;
    logic        wr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Most recent accepted operation: the EX/MEM occupant when the next one executes
  bit          prev_live = 1'b0;
  logic        prev_wr;
  logic [4:0]  prev_rd;
  logic [63:0] prev_res;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_alu(input logic [3:0] c, input logic [63:0] a,
                                          input logic [63:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      default: return '1;
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] rs1, input logic [4:0] rs2, input bit imm,
                      input logic [4:0] rd, input bit wr, input bit keep);
    int          guard = 0;
    logic [63:0] ea;
    logic [63:0] eb;
    exp_t        e;
    in_valid   = 1'b1;
    in_a       = a;
    in_b       = b;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_b_imm   = imm;
    in_alu_ctl = c;
    in_rd      = rd;
    in_wr      = wr;
    #1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    ea = (prev_live && prev_wr && prev_rd == rs1 && rs1 != 5'd31) ? prev_res : a;
    eb = (prev_live && prev_wr && prev_rd == rs2 && rs2 != 5'd31 && !imm) ? prev_res : b;
    e.res = ref_alu(c, ea, eb);
    e.z   = (e.res == 64'd0);
    e.rd  = rd;
    e.wr  = wr;
    if (keep) begin
      sb.push_back(e);
      prev_live = 1'b1;
      prev_wr   = wr;
      prev_rd   = rd;
      prev_res  = e.res;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_empty", sb.size(), 0);
    repeat (2) @(negedge clk);
    prev_live = 1'b0;
  endtask

  // Output monitor: a handshake seen here completes on the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {59'd0, out_rd}, 64'hFFFF);
        end else begin
          e = sb.pop_front();
          chk("result", out_result, e.res);
          chk("zero", out_zero, e.z);
          chk("rd", out_rd, e.rd);
          chk("wr", out_wr, e.wr);
        end
      end
    end
  end

  initial begin
    logic [63:0] held;
    reset      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    in_rs1     = '0;
    in_rs2     = '0;
    in_b_imm   = 1'b0;
    in_alu_ctl = '0;
    in_rd      = '0;
    in_wr      = 1'b0;
    out_ready  = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_wr", out_wr, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b1;
    @(negedge clk);

    // Single ADD with latency check
    send(4'b0010, 64'd5, 64'd7, 5'd10, 5'd11, 0, 5'd3, 1, 1);
    #1 chk("lat_not_yet", out_valid, 0);
    @(negedge clk);
    #1 chk("lat_valid", out_valid, 1);
    chk("lat_result", out_result, 64'd12);
    drain();

    // Operation mix, back to back
    send(4'b0110, 64'd9, 64'd9, 5'd1, 5'd2, 0, 5'd20, 1, 1);
    send(4'b1111, 64'd3, 64'd4, 5'd3, 5'd4, 0, 5'd21, 1, 1);
    send(4'b0000, 64'hF0F0, 64'hFF00, 5'd5, 5'd6, 0, 5'd22, 1, 1);
    send(4'b0001, 64'hF0F0, 64'h0F0F, 5'd7, 5'd8, 0, 5'd23, 1, 1);
    send(4'b0111, 64'd77, 64'h1234, 5'd9, 5'd10, 0, 5'd0, 0, 1);
    send(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd11, 5'd12, 0, 5'd24, 1, 1);
    send(4'b0110, 64'd0, 64'd1, 5'd13, 5'd14, 0, 5'd25, 1, 1);
    drain();

    // Forwarding and its exceptions
    send(4'b0010, 64'd2, 64'd3, 5'd10, 5'd11, 0, 5'd1, 1, 1);
    send(4'b0010, 64'd100, 64'd1, 5'd1, 5'd12, 0, 5'd2, 1, 1);
    send(4'b0110, 64'd50, 64'd999, 5'd13, 5'd2, 0, 5'd5, 1, 1);
    send(4'b0010, 64'd2, 64'd3, 5'd10, 5'd11, 0, 5'd31, 1, 1);
    send(4'b0010, 64'd100, 64'd1, 5'd31, 5'd12, 0, 5'd2, 1, 1);
    send(4'b0010, 64'd8, 64'd0, 5'd14, 5'd15, 0, 5'd4, 1, 1);
    send(4'b0010, 64'd1, 64'd10, 5'd20, 5'd4, 1, 5'd6, 1, 1);
    send(4'b0010, 64'd1, 64'd1, 5'd16, 5'd17, 0, 5'd7, 0, 1);
    send(4'b0010, 64'd30, 64'd0, 5'd7, 5'd18, 0, 5'd8, 1, 1);
    drain();

    // Back-pressure: three offered, two accepted, outputs frozen for 4 cycles
    out_ready = 1'b0;
    fork
      begin
        send(4'b0010, 64'd10, 64'd20, 5'd1, 5'd2, 0, 5'd9, 1, 1);
        send(4'b0010, 64'd500, 64'd5, 5'd9, 5'd3, 0, 5'd10, 1, 1);
        send(4'b0110, 64'd1, 64'd3, 5'd10, 5'd4, 0, 5'd11, 1, 1);
      end
      begin
        repeat (3) @(negedge clk);
        #1;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        held = out_result;
        @(negedge clk);
        chk("bp_hold", out_result, held);
        chk("bp_hold_val", out_result, 64'd30);
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush kills the ID/EX occupant; EX/MEM is untouched
    out_ready = 1'b0;
    send(4'b0010, 64'd40, 64'd2, 5'd1, 5'd2, 0, 5'd7, 1, 1);
    send(4'b0111, 64'd0, 64'hDEAD, 5'd3, 5'd4, 0, 5'd9, 1, 0);
    flush = 1'b1;
    #1 chk("flush_in_ready", in_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("flush_s2_kept", out_valid, 1);
    @(negedge clk);
    send(4'b0010, 64'd1000, 64'd8, 5'd7, 5'd31, 0, 5'd12, 1, 1);
    out_ready = 1'b1;
    drain();

    // Reset in the middle of traffic
    out_ready = 1'b0;
    send(4'b0010, 64'd3, 64'd4, 5'd1, 5'd2, 0, 5'd13, 1, 1);
    send(4'b0010, 64'd5, 64'd6, 5'd3, 5'd4, 0, 5'd14, 1, 1);
    chk("pre_rst_valid", out_valid, 1);
    reset = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_result", out_result, 0);
    chk("midrst_zero", out_zero, 0);
    chk("midrst_rd", out_rd, 0);
    chk("midrst_wr", out_wr, 0);
    chk("midrst_in_ready", in_ready, 1);
    sb.delete();
    prev_live = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    send(4'b0001, 64'h10, 64'h01, 5'd13, 5'd14, 0, 5'd15, 1, 1);
    drain();

    chk("sb_final_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe_stage.md
# alu_pipe_stage

Elastic two-register execute stage for the 64-bit datapath. It captures decoded operands into an ID/EX register and drives the combinational `alu` from that register. It forwards its own EX/MEM result back to dependent operands and registers result, zero flag and destination into an EX/MEM register. Both ends use valid/ready handshakes, so the stage throttles decode and the memory stage consumes from it.

## Interface
- `N`, 64, datapath width
- `RW`, 5, register-index width; index 31 is XZR and is never forwarded
- `clk` in 1, rising-edge clock
- `reset` in 1, asynchronous, active-low; clears all state
- `flush` in 1, kills ID/EX contents and blocks input acceptance this cycle
- `in_valid` in 1, upstream has an operation
- `in_ready` out 1, stage accepts this cycle
- `in_a` in N, register-file value of first source
- `in_b` in N, register-file value or immediate
- `in_rs1`, `in_rs2` in RW, source indices
- `in_b_imm` in 1, `in_b` is immediate (no forwarding on b)
- `in_alu_ctl` in 4, ALU operation code
- `in_rd` in RW, destination index
- `in_wr` in 1, operation writes `in_rd`
- `out_valid` out 1, EX/MEM holds a result
- `out_ready` in 1, downstream accepts
- `out_result` out N, registered ALU result
- `out_zero` out 1, registered (result == 0)
- `out_rd` out RW, registered destination
- `out_wr` out 1, registered write enable

## Operation
- Stage S1 (ID/EX) holds: a, b, rs1, rs2, b_imm, ctl, rd, wr, s1_valid. Stage S2 (EX/MEM) holds: result, zero, rd, wr, s2_valid.
- Advance conditions: `adv2 = !s2_valid | out_ready`; `adv1 = s1_valid & adv2`.
- `in_ready = !flush & (!s1_valid | adv2)`.
- Input accepted when `in_valid & in_ready`. S1 loads the inputs and s1_valid becomes 1.
- Operand a: if `s2_valid & s2_wr & s2_rd == s1_rs1 & s1_rs1 != 31`, use the S2 result; otherwise use S1 a.
- Operand b: same rule on rs2, suppressed when `s1_b_imm`.
- The ALU computes from the selected operands. Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 pass b. Any other code gives all-ones.
- Arithmetic wraps modulo 2^N. No carry or overflow is produced.
- On adv1, S2 loads result, zero, rd and wr, and s2_valid becomes 1.
- On adv2 without adv1, s2_valid becomes 0.
- S1 valid update:
  - Accept → 1.
  - adv1 without accept → 0.
  - Otherwise held.
- Flush: s1_valid becomes 0 next edge and no input is accepted. S2 is unaffected and still hands off normally.
- Flush with adv1 in the same cycle: S1's operation is still killed and S2 does not load it, so s2_valid follows adv2 alone.
- Back-pressure: while `out_ready = 0` and s2_valid is 1, S2 holds and S1 holds. With S1 also full, in_ready = 0.
- Forwarding uses S2's value during the same cycle S2 is dequeued. Older results are the register file's responsibility.

## Timing
- Latency: an operation accepted at edge t appears with out_valid at edge t+1, i.e. two registers, visible one cycle after S1 capture.
- Throughput: one operation per cycle when out_ready is held at 1.
- Reset (asynchronous, active-low): s1_valid = s2_valid = 0. All data registers are 0, so out_result = 0, out_zero = 0, out_rd = 0, out_wr = 0.
- in_ready = 1 during reset deassertion unless flush is asserted.
- Reset mid-operation: in-flight operations are lost and no output handshake occurs.
- out_* are pure register outputs. No combinational path from in_* to out_*.
- in_ready depends combinationally on out_ready and flush.

## Structure
- Package `alu_pkg`: ALU control constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB), XZR index 31, and a struct for the S1 payload.
- One sub-module: `alu` (N=N), instantiated combinationally between S1 and S2.
- Forward muxes and handshake logic stay inline.

## Test plan
- Reset then a single ADD, a=5 b=7 ctl=0010 rd=3 → out_valid one cycle after acceptance, result=12, zero=0, rd=3.
- SUB a=9 b=9 → result=0, zero=1. Undefined ctl=1111 → result=all-ones, zero=0.
- Back-to-back ADD X1=2+3, then ADD rs1=X1 with stale in_a=100, b=1 → second result=6 (forwarded).
- Same dependent pair with rd=31, or with in_b_imm=1 and rs2 matching → no forwarding; uses in_a or in_b.
- Hold out_ready=0 for 4 cycles with 3 operations offered → in_ready drops after 2 accepted. Outputs stay stable and ordering is preserved once released.
- Assert flush with S1 full → that operation never appears at the output. Assert reset mid-stream → all out_* = 0 immediately.
